// File: rtl/core_mc_pkg.sv
// core_mc shared types: opcodes, FSM states, flags and ALU functions.
// Default parameter values for the multi-cycle core live here too.
package pico_mc;

  localparam int N_DEF        = 8;
  localparam int A_DEF        = 8;
  localparam int W_RADDR_DEF  = 3;
  localparam int W_IMM_DEF    = 8;
  localparam int W_OPCODE_DEF = 4;
  localparam int W_INST_DEF   =
    W_OPCODE_DEF + 2 * W_RADDR_DEF + W_IMM_DEF;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LDI  = 4'h7,
    OP_MOV  = 4'h8,
    OP_IN   = 4'h9,
    OP_BZ   = 4'hA,
    OP_BNZ  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RSD  = 4'hD,
    OP_RSE  = 4'hE,
    OP_HALT = 4'hF
  } opCodeMc;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_EXT,
    S_HALT
  } stateMc;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flagsMc;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_PASS
  } aluFnMc;

endpackage

// File: rtl/core_mc_if.sv
// Fetch port and external-data handshake of core_mc.
// master is the core side, slave the memory / source side.
import pico_mc::*;

interface core_mc_if #(
  parameter int N      = N_DEF,
  parameter int A      = A_DEF,
  parameter int W_INST = W_INST_DEF
) ();

  logic [A-1:0]      imem_addr_o;
  logic              imem_req_o;
  logic              imem_ack_i;
  logic [W_INST-1:0] imem_data_i;
  logic [N-1:0]      ext_data_i;
  logic              ext_valid_i;
  logic              ext_ready_o;

  modport master (
    output imem_addr_o,
    output imem_req_o,
    input  imem_ack_i,
    input  imem_data_i,
    input  ext_data_i,
    input  ext_valid_i,
    output ext_ready_o
  );

  modport slave (
    input  imem_addr_o,
    input  imem_req_o,
    output imem_ack_i,
    output imem_data_i,
    output ext_data_i,
    output ext_valid_i,
    input  ext_ready_o
  );

endinterface

// File: rtl/core_mc_alu.sv
// Combinational N-bit ALU with Z/N/C/V generation for core_mc.
// C is carry for ADD, borrow (a < b unsigned) for SUB.
import pico_mc::*;

module alu_p #(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  aluFnMc       fn_i,
  output logic [N-1:0] y_o,
  output flagsMc       flags_o
);

  logic [N-1:0] y;
  logic         c;
  logic         v;

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (fn_i)
      ALU_ADD: begin
        {c, y} = {1'b0, a_i} + {1'b0, b_i};
        v = (a_i[N-1] == b_i[N-1]) &&
            (y[N-1] != a_i[N-1]);
      end
      ALU_SUB: begin
        y = a_i - b_i;
        c = a_i < b_i;
        v = (a_i[N-1] != b_i[N-1]) &&
            (y[N-1] != a_i[N-1]);
      end
      ALU_AND:  y = a_i & b_i;
      ALU_OR:   y = a_i | b_i;
      ALU_XOR:  y = a_i ^ b_i;
      ALU_PASS: y = b_i;
      default:  y = '0;
    endcase
  end

  assign y_o       = y;
  assign flags_o.z = (y == '0);
  assign flags_o.n = y[N-1];
  assign flags_o.c = c;
  assign flags_o.v = v;

endmodule

// File: rtl/core_mc.sv
// Multi-cycle processing element: FETCH / EXEC / WAIT_EXT / HALT.
// Fetch is req/ack so instruction memory latency may vary.
import pico_mc::*;

module core_mc #(
  parameter int N        = N_DEF,
  parameter int A        = A_DEF,
  parameter int W_RADDR  = W_RADDR_DEF,
  parameter int W_IMM    = W_IMM_DEF,
  parameter int W_OPCODE = W_OPCODE_DEF,
  parameter int W_INST   = W_OPCODE + 2 * W_RADDR + W_IMM
) (
  input  logic         clk_i,
  input  logic         rst_i,
  core_mc_if.master    bus,
  output logic [N-1:0] result_o,
  output logic         halt_o
);

  localparam int NREG = 2 ** W_RADDR;

  stateMc            state_q;
  stateMc            state_d;
  logic [A-1:0]      pc_q;
  logic [A-1:0]      pc_d;
  logic [W_INST-1:0] ir_q;
  flagsMc            flags_q;
  logic [N-1:0]      rf_q [NREG];

  opCodeMc           op;
  logic [W_RADDR-1:0] rd;
  logic [W_RADDR-1:0] rs;
  logic [W_IMM-1:0]  imm;
  logic [N-1:0]      imm_n;
  logic [A-1:0]      imm_pc;
  logic [A-1:0]      imm_jmp;
  logic [A-1:0]      pc_inc;
  logic [N-1:0]      rd_val;
  logic [N-1:0]      rs_val;
  logic              alu_op;

  aluFnMc            alu_fn;
  logic [N-1:0]      alu_b;
  logic [N-1:0]      alu_y;
  flagsMc            alu_flags;

  logic              ir_we;
  logic              rf_we;
  logic              flags_we;
  logic              halt_set;
  logic [N-1:0]      wdata;

  assign op      = opCodeMc'(ir_q[W_INST-1 -: W_OPCODE]);
  assign rd      = ir_q[W_IMM+W_RADDR +: W_RADDR];
  assign rs      = ir_q[W_IMM +: W_RADDR];
  assign imm     = ir_q[W_IMM-1:0];
  assign imm_n   = N'($signed(imm));
  assign imm_pc  = A'($signed(imm));
  assign imm_jmp = A'(imm);
  assign pc_inc  = pc_q + A'(1);
  // r0 is never written, so it always reads back as zero
  assign rd_val  = rf_q[rd];
  assign rs_val  = rf_q[rs];
  assign alu_op  = (op >= OP_ADD) && (op <= OP_MOV);

  assign bus.imem_req_o  = (state_q == S_FETCH);
  assign bus.imem_addr_o = pc_q;
  assign bus.ext_ready_o = (state_q == S_WAIT_EXT);

  always_comb begin
    alu_fn = ALU_PASS;
    alu_b  = rs_val;
    case (op)
      OP_ADD:  alu_fn = ALU_ADD;
      OP_SUB:  alu_fn = ALU_SUB;
      OP_AND:  alu_fn = ALU_AND;
      OP_OR:   alu_fn = ALU_OR;
      OP_XOR:  alu_fn = ALU_XOR;
      OP_ADDI: begin
        alu_fn = ALU_ADD;
        alu_b  = imm_n;
      end
      OP_LDI:  alu_b = imm_n;
      default: ;
    endcase
  end

  alu_p #(.N(N)) u_alu (
    .a_i     (rd_val),
    .b_i     (alu_b),
    .fn_i    (alu_fn),
    .y_o     (alu_y),
    .flags_o (alu_flags)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    flags_we = 1'b0;
    halt_set = 1'b0;
    wdata    = alu_y;
    unique case (state_q)
      S_FETCH: begin
        if (bus.imem_ack_i) begin
          ir_we   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d  = S_FETCH;
        pc_d     = pc_inc;
        rf_we    = alu_op;
        flags_we = alu_op;
        case (op)
          OP_IN: begin
            state_d = S_WAIT_EXT;
            pc_d    = pc_q;
          end
          OP_BZ:
            if (flags_q.z) pc_d = pc_q + imm_pc;
          OP_BNZ:
            if (!flags_q.z) pc_d = pc_q + imm_pc;
          OP_JMP:  pc_d = imm_jmp;
          OP_HALT: begin
            state_d  = S_HALT;
            pc_d     = pc_q;
            halt_set = 1'b1;
          end
          default: ;
        endcase
      end
      S_WAIT_EXT: begin
        if (bus.ext_valid_i) begin
          rf_we   = 1'b1;
          wdata   = bus.ext_data_i;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      ir_q     <= '0;
      flags_q  <= '0;
      result_o <= '0;
      halt_o   <= 1'b0;
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (ir_we)    ir_q    <= bus.imem_data_i;
      if (flags_we) flags_q <= alu_flags;
      if (halt_set) halt_o  <= 1'b1;
      // result_o shows the value even when rd is r0
      if (rf_we) begin
        result_o <= wdata;
        if (rd != '0) rf_q[rd] <= wdata;
      end
    end
  end

endmodule

// File: doc/core_mc.md
# core_mc

Multi-cycle, parametrised successor to the single-cycle pico core. It fetches instructions over a request/acknowledge port, so memory latency can vary. It stalls on an external-data handshake and keeps registered ALU flags. The block is a drop-in processing element that sits between an instruction memory of any latency and an external input source.

## Interface
- N, 8: data/register width (≥4)
- A, 8: instruction address width
- W_RADDR, 3: register address width; 2**W_RADDR registers
- W_IMM, 8: immediate width (≤N)
- W_OPCODE, 4: opcode width (fixed at 4; other values illegal)
- W_INST, W_OPCODE+2*W_RADDR+W_IMM: instruction width (derived)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous and active-high
- imem_addr_o  out  A  fetch address, equals the PC
- imem_req_o  out  1  fetch request
- imem_ack_i  in  1  fetch acknowledge; imem_data_i is valid in the same cycle
- imem_data_i  in  W_INST  instruction word
- ext_data_i  in  N  signed external operand
- ext_valid_i  in  1  ext_data_i valid
- ext_ready_o  out  1  core is consuming ext_data_i this cycle
- result_o  out  N  signed; last value written to the register file (registered)
- halt_o  out  1  core halted (registered, sticky)

## Operation
- Instruction fields, LSB first: imm [W_IMM-1:0], rs, rd, opcode at the top.
- Register file: r0 reads 0 and writes to it are discarded. All other registers reset to 0.
- Opcodes and their operations:
  - 0 NOP
  - 1 ADD: rd = rd + rs
  - 2 SUB: rd = rd - rs
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI: rd = rd + sext(imm)
  - 7 LDI: rd = sext(imm)
  - 8 MOV: rd = rs
  - 9 IN: rd = ext_data_i
  - A BZ: if Z, PC = PC + sext(imm)
  - B BNZ: if !Z, PC = PC + sext(imm)
  - C JMP: PC = imm[A-1:0], zero-extended if W_IMM<A
  - D, E: reserved, execute as NOP
  - F HALT
- Flags Z, Nf, C, V are registered. They are updated only by opcodes 1–8; IN, branches and NOP leave them unchanged.
  - Z: result == 0
  - Nf: result MSB
  - C: carry out of the N-bit add, or borrow (rd < rs unsigned) for SUB. Cleared for logic ops, LDI and MOV.
  - V: signed overflow for ADD/ADDI/SUB. Cleared otherwise.
- All arithmetic is N-bit modular. The PC is A-bit modular, so branches and increments wrap.
- State machine: FETCH, EXEC, WAIT_EXT, HALT.
  - FETCH: imem_req_o=1, imem_addr_o=PC. When imem_ack_i=1, latch imem_data_i into IR and go to EXEC. Otherwise stay.
  - EXEC: decode IR and write back. Set PC = PC+1 or the branch target, then go to FETCH.
    - IN goes to WAIT_EXT and leaves the PC unchanged.
    - HALT goes to HALT and leaves the PC unchanged.
  - WAIT_EXT: ext_ready_o=1. When ext_valid_i=1, write rd=ext_data_i, set PC = PC+1 and go to FETCH.
  - HALT: halt_o=1. No request is issued and all state is frozen until reset.
- result_o updates only on a register-file write, including a write to r0, which still shows the computed value.

## Timing
- Reset values: PC=0, state=FETCH, flags=0, IR=0, result_o=0, halt_o=0, ext_ready_o=0.
- imem_req_o is 1 in the first cycle after reset is released.
- imem_req_o and imem_addr_o are combinational from state and PC. They must stay stable while unacknowledged.
- An ack seen outside FETCH is ignored.
- Instruction latency is fetch wait + 2 cycles; with a zero-wait ack this is 2 cycles.
- IN costs at least 3 cycles. The ext handshake completes in the cycle where ext_valid_i && ext_ready_o.
- The branch decision uses the flags as registered before the EXEC cycle.
- halt_o rises on the clock edge that ends the EXEC cycle of HALT.
- rst_i asserted in any state, including mid-fetch or WAIT_EXT, returns to reset values on the next edge. A pending ack or ext_valid_i in that cycle is discarded.

## Structure
- Package pico_mc holds:
  - the opcode enum opCodeMc
  - the state enum stateMc
  - the flags struct flagsMc {z, n, c, v}
  - the ALU function enum
  - default parameter constants
- Sub-module alu_p (parametrised on N) does the combinational ALU and flag generation.
- The register file, IR, PC and FSM are inline in core_mc.

## Test plan
All scenarios use default parameters.
- Reset and fetch: hold rst_i for 3 cycles, then release with imem_ack_i held high.
  - imem_req_o=1 with address 0 on the first cycle after release.
  - result_o=0 and halt_o=0 throughout.
- Arithmetic with zero-wait ack: LDI r1,5; LDI r2,-3; ADD r1,r2; SUB r2,r1.
  - result_o sequence 5, 0xFD, 2, 0xFB.
  - After the ADD, C=1 and Z=0.
  - Each instruction takes 2 cycles.
- Overflow: LDI r1,127; ADDI r1,1.
  - result_o=0x80, V=1, Nf=1.
- Branch: LDI r1,1; SUB r1,r1; BZ -2.
  - Z=1 and the PC goes from 2 to 0.
  - Repeat with BNZ: the PC goes to 3.
  - A branch of -3 from PC 0 wraps to 0xFD.
- Fetch wait and IN: ack delayed 4 cycles; address held stable throughout. Then IN r3 with ext_valid_i low for 5 cycles, then high with ext_data_i=0x42.
  - ext_ready_o is high for 6 cycles.
  - r3=0x42 and result_o=0x42.
- Halt and reset mid-WAIT_EXT:
  - HALT: halt_o=1, imem_req_o stays at 0, and the PC stays frozen for 20 cycles.
  - Assert rst_i during WAIT_EXT: state returns to FETCH, PC=0, and that ext_valid_i is ignored.
